// File: rtl/slc3_btn_pkg.sv
// Shared types and default parameters for the SLC-3 push-button conditioner.
// Optional feature macro: BTN_AUTOREPEAT_EN (enables hold-to-repeat presses).
package slc3_btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // 1 ms at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    // 0.5 s to first repeat, then 10 repeats per second
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    // Short debounce window so simulations reach accepted presses quickly
    localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, debounce FSM with stable-cycle
// counter, registered level and one-cycle press/release pulses.
// Optional feature macro: BTN_AUTOREPEAT_EN adds a hold counter that emits
// extra press pulses while the button stays down.
//
// state        | meaning
// -------------+-------------------------------------------------------
// RELEASED     | button up and accepted as up
// PRESS_PEND   | input went down, counting stable-low cycles
// PRESSED      | button down and accepted as down (level = 1)
// RELEASE_PEND | input went up, counting stable-high cycles (level = 1)
module btn_debounce_ch
    import slc3_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             s;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_d;
    logic             release_d;
    logic             press_any;

    assign s = sync_q2;

    // Two-stage synchroniser; resets to the released (high) KEY level
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce next-state: any bounce back to the accepted level restarts the count
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            PRESS_PEND: begin
                if (s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (s) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            RELEASE_PEND: begin
                if (!s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and debounce counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              armed_q;
    logic              repeat_fire;

    // armed_q selects the repeat period once the first repeat has been issued
    assign repeat_fire = (state_q == PRESSED) && !s &&
                         (hold_q == (armed_q ? PERIOD_LAST : DELAY_LAST));

    // Hold counter only runs while steadily PRESSED; any other cycle rearms the delay
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else if (state_q != PRESSED || s) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else if (repeat_fire) begin
            hold_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign press_any = press_d | repeat_fire;
`else
    assign press_any = press_d;
`endif

    // Registered outputs; level follows the state being entered so it moves with the pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= (state_d == PRESSED) || (state_d == RELEASE_PEND);
            press_pulse   <= press_any;
            release_pulse <= release_d;
        end
    end

endmodule

// File: rtl/slc3_button_conditioner.sv
// SLC-3 push-button front end: N_BTN independent debounced channels between
// the board KEYs (active-low, asynchronous) and the SLC-3 top.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat press pulses,
// exposes REPEAT_DELAY / REPEAT_PERIOD parameters).
module slc3_button_conditioner
    import slc3_btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] Btn_n,
    output logic [N_BTN-1:0] Btn_level,
    output logic [N_BTN-1:0] Btn_press,
    output logic [N_BTN-1:0] Btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .Clk           (Clk),
            .Reset_n       (Reset_n),
            .btn_n         (Btn_n[i]),
            .level         (Btn_level[i]),
            .press_pulse   (Btn_press[i]),
            .release_pulse (Btn_release[i])
        );
    end

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Bench for slc3_button_conditioner with a short debounce window.
// Build with or without BTN_AUTOREPEAT_EN; expectations follow the macro.
module tb_slc3_button_conditioner;
    import slc3_btn_pkg::*;

    localparam int NB = 2;
    localparam int DB = SIM_DEBOUNCE_CYCLES;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RP = 3;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [NB-1:0] Btn_n = 2'b11;
    logic [NB-1:0] Btn_level;
    logic [NB-1:0] Btn_press;
    logic [NB-1:0] Btn_release;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 Clk = ~Clk;

    slc3_button_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DB)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Btn_n       (Btn_n),
        .Btn_level   (Btn_level),
        .Btn_press   (Btn_press),
        .Btn_release (Btn_release)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Edge counter: after posedge k, cyc == k
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural model: the input seen two edges late must disagree with the
    // accepted level for DB+1 consecutive edges before the level flips.
    logic [NB-1:0] m_s1, m_s2, exp_level, exp_press, exp_release;
    int run_len [NB];
`ifdef BTN_AUTOREPEAT_EN
    int since [NB];
    int due   [NB];
`endif

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_s1 = '1;
            m_s2 = '1;
            exp_level = '0;
            exp_press = '0;
            exp_release = '0;
            for (int ch = 0; ch < NB; ch++) begin
                run_len[ch] = 0;
`ifdef BTN_AUTOREPEAT_EN
                since[ch] = 0;
                due[ch] = RD;
`endif
            end
        end else begin : model_step
            logic [NB-1:0] s;
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = Btn_n;
            for (int ch = 0; ch < NB; ch++) begin
                exp_press[ch] = 1'b0;
                exp_release[ch] = 1'b0;
                if ((!s[ch]) != exp_level[ch]) begin
                    run_len[ch]++;
                    if (run_len[ch] == DB + 1) begin
                        exp_level[ch] = ~exp_level[ch];
                        run_len[ch] = 0;
                        if (exp_level[ch]) exp_press[ch] = 1'b1;
                        else               exp_release[ch] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        since[ch] = 0;
                        due[ch] = RD;
`endif
                    end
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (exp_level[ch]) begin
                        if (run_len[ch] > 0) begin
                            since[ch] = 0;
                            due[ch] = RD;
                        end else begin
                            since[ch]++;
                            if (since[ch] == due[ch]) begin
                                exp_press[ch] = 1'b1;
                                since[ch] = 0;
                                due[ch] = RP;
                            end
                        end
                    end
`endif
                    run_len[ch] = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model while out of reset
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("level",   int'(Btn_level),   int'(exp_level));
            chk("press",   int'(Btn_press),   int'(exp_press));
            chk("release", int'(Btn_release), int'(exp_release));
        end
    end

    // Pulse observers used by the hand-computed checks
    int press_cnt [NB];
    int rel_cnt   [NB];
    int press_cyc [NB];
    int rel_cyc   [NB];
    int pq0 [$];

    always @(negedge Clk) begin
        for (int ch = 0; ch < NB; ch++) begin
            if (Btn_press[ch]) begin
                if (press_cnt[ch] == 0) press_cyc[ch] = cyc;
                press_cnt[ch]++;
                if (ch == 0) pq0.push_back(cyc);
            end
            if (Btn_release[ch]) begin
                if (rel_cnt[ch] == 0) rel_cyc[ch] = cyc;
                rel_cnt[ch]++;
            end
        end
    end

    task automatic clear_obs();
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch] = 0;
            rel_cnt[ch] = 0;
            press_cyc[ch] = -1;
            rel_cyc[ch] = -1;
        end
        pq0.delete();
    endtask

    // Advance n cycles; inputs change 2 time units after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    int c0, c1;

    initial begin
        clear_obs();
        step(3);
        chk("reset_level", int'(Btn_level), 0);
        chk("reset_press", int'(Btn_press), 0);
        Reset_n = 1'b1;
        step(2);

        // 1: press both, async reset mid-run, held keys re-reported after reset
        Btn_n = 2'b00;
        step(10);
        chk("t1_level_before_rst", int'(Btn_level), 3);
        Reset_n = 1'b0;
        #1;
        chk("t1_rst_level",   int'(Btn_level),   0);
        chk("t1_rst_press",   int'(Btn_press),   0);
        chk("t1_rst_release", int'(Btn_release), 0);
        step(3);
        Reset_n = 1'b1;
        c0 = cyc + 1;
        clear_obs();
        step(10);
        chk("t1_press_edge0", press_cyc[0] - c0, 6);
        chk("t1_press_edge1", press_cyc[1] - c0, 6);
        chk("t1_press_cnt0",  press_cnt[0], 1);
        chk("t1_level",       int'(Btn_level), 3);
        Btn_n = 2'b11;
        step(12);
        chk("t1_level_rel", int'(Btn_level), 0);

        // 2: 3-cycle bounce on ch0 is rejected
        clear_obs();
        Btn_n = 2'b10;
        step(3);
        Btn_n = 2'b11;
        step(10);
        chk("t2_press_cnt", press_cnt[0], 0);
        chk("t2_level",     int'(Btn_level[0]), 0);

        // 3: 20-cycle press on ch0
        clear_obs();
        c0 = cyc + 1;
        Btn_n = 2'b10;
        step(10);
        chk("t3_level_mid", int'(Btn_level[0]), 1);
        step(10);
        c1 = cyc + 1;
        Btn_n = 2'b11;
        step(12);
        chk("t3_press_edge",   press_cyc[0] - c0, 6);
        chk("t3_release_edge", rel_cyc[0] - c1, 6);
        chk("t3_release_cnt",  rel_cnt[0], 1);
`ifndef BTN_AUTOREPEAT_EN
        chk("t3_press_cnt", press_cnt[0], 1);
`endif

        // 4: 2-cycle high glitch on ch1 while pressed
        clear_obs();
        Btn_n = 2'b01;
        step(10);
        Btn_n = 2'b11;
        step(2);
        Btn_n = 2'b01;
        step(8);
        chk("t4_no_release", rel_cnt[1], 0);
        chk("t4_level",      int'(Btn_level[1]), 1);
        Btn_n = 2'b11;
        step(12);
        chk("t4_release_cnt", rel_cnt[1], 1);

        // 5: simultaneous press, ch1 released early
        clear_obs();
        c0 = cyc + 1;
        Btn_n = 2'b00;
        step(10);
        chk("t5_press_edge0", press_cyc[0] - c0, 6);
        chk("t5_press_edge1", press_cyc[1] - c0, 6);
        Btn_n = 2'b10;
        step(10);
        chk("t5_rel_cnt1",  rel_cnt[1], 1);
        chk("t5_rel_cnt0",  rel_cnt[0], 0);
        chk("t5_level0",    int'(Btn_level[0]), 1);
        Btn_n = 2'b11;
        step(12);

        // 6: ch0 held 30 cycles (auto-repeat when enabled)
        clear_obs();
        c0 = cyc + 1;
        Btn_n = 2'b10;
        step(30);
        Btn_n = 2'b11;
        step(12);
        chk("t6_first_press", press_cyc[0] - c0, 6);
`ifdef BTN_AUTOREPEAT_EN
        chk("t6_press_cnt", press_cnt[0], 7);
        if (pq0.size() >= 4) begin
            chk("t6_gap_delay",   pq0[1] - pq0[0], 10);
            chk("t6_gap_period1", pq0[2] - pq0[1], 3);
            chk("t6_gap_period2", pq0[3] - pq0[2], 3);
        end else begin
            chk("t6_repeat_count_min", pq0.size(), 4);
        end
`else
        chk("t6_press_cnt", press_cnt[0], 1);
`endif
        clear_obs();
        step(20);
        chk("t6_none_after_release", press_cnt[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
